tow_round_ctrl: RTL and testbench

- Round controller and scorer directly downstream of the push-button latch stage of the tug-of-war game.
- Consumes `push`, `tie` and `right` from that stage and drives its `clr` input.
- Moves a one-hot rope position along the LED bar, detects a win at either end and keeps per-player win tallies.
- One instance per game, in the board clock domain.

---
 rtl/tow_pkg.sv | 18 +
 rtl/tow_quiet_timer.sv | 34 +++
 rtl/tow_round_ctrl.sv | 161 ++++++++++++++++
 tb/tb_tow_round_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// Shared types and helpers for the tug-of-war round controller.
package tow_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SCORE = 2'd2,
    ST_WIN   = 2'd3
  } tow_state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic int pos_width(input int num_leds);
    return (num_leds > 1) ? $clog2(num_leds) : 1;
  endfunction

endpackage

// File: rtl/tow_quiet_timer.sv
// Counts consecutive cycles without a button press; done fires on the cycle
// that completes HOLD_CYCLES quiet cycles and the count restarts from zero.
module tow_quiet_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic push,
  output logic done
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    done  = enable && !push && (cnt_q == LAST);
    cnt_d = cnt_q + 1'b1;
    if (!enable || push || done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tow_round_ctrl.sv
// Tug-of-war round controller: arms after a quiet period, moves the rope one
// LED per scored push, detects wins at either end and keeps saturating tallies.
module tow_round_ctrl
  import tow_pkg::*;
#(
  parameter int NUM_LEDS    = 7,
  parameter int HOLD_CYCLES = 4,
  parameter int WIN_W       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                tie,
  input  logic                right,
  input  logic                new_game,
  output logic                clr,
  output logic [NUM_LEDS-1:0] leds,
  output logic                game_over,
  output logic                winner_right,
  output logic [WIN_W-1:0]    left_wins,
  output logic [WIN_W-1:0]    right_wins
);

  localparam int PW = pos_width(NUM_LEDS);
  localparam logic [PW-1:0] POS_MAX = PW'(NUM_LEDS - 1);
  localparam logic [PW-1:0] POS_CTR = PW'((NUM_LEDS - 1) / 2);

  tow_state_e state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic tie_q, tie_d, right_q, right_d, winner_q, winner_d;
  logic [WIN_W-1:0] lw_q, lw_d, rw_q, rw_d;
  logic clr_q, clr_d, go_q, go_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic quiet_en, quiet_done;

  function automatic logic [WIN_W-1:0] sat_inc(input logic [WIN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The timer only runs in IDLE; leaving IDLE or a new game restarts it.
  assign quiet_en = (state_q == ST_IDLE) && !new_game;

  tow_quiet_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_quiet (
    .clk   (clk),
    .rst   (rst),
    .enable(quiet_en),
    .push  (push),
    .done  (quiet_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      pos_q    <= POS_CTR;
      tie_q    <= 1'b0;
      right_q  <= 1'b0;
      winner_q <= 1'b0;
      lw_q     <= '0;
      rw_q     <= '0;
      clr_q    <= 1'b1;
      go_q     <= 1'b0;
      leds_q   <= NUM_LEDS'(1) << POS_CTR;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      tie_q    <= tie_d;
      right_q  <= right_d;
      winner_q <= winner_d;
      lw_q     <= lw_d;
      rw_q     <= rw_d;
      clr_q    <= clr_d;
      go_q     <= go_d;
      leds_q   <= leds_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (quiet_done) state_d = ST_ARMED;
        ST_ARMED: if (push) state_d = ST_SCORE;
        ST_SCORE: begin
          if (tie_q) begin
            state_d = ST_IDLE;
          end else if (right_q == DIR_RIGHT) begin
            state_d = (pos_q == POS_MAX) ? ST_WIN : ST_IDLE;
          end else begin
            state_d = (pos_q == '0) ? ST_WIN : ST_IDLE;
          end
        end
        ST_WIN:   state_d = ST_WIN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pos_d    = pos_q;
    tie_d    = tie_q;
    right_d  = right_q;
    winner_d = winner_q;
    lw_d     = lw_q;
    rw_d     = rw_q;
    if (new_game) begin
      pos_d = POS_CTR;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (push) begin
            tie_d   = tie;
            right_d = right;
          end
        end
        ST_SCORE: begin
          if (!tie_q) begin
            if (right_q == DIR_RIGHT) begin
              if (pos_q == POS_MAX) begin
                winner_d = DIR_RIGHT;
                rw_d     = sat_inc(rw_q);
              end else begin
                pos_d = pos_q + 1'b1;
              end
            end else begin
              if (pos_q == '0) begin
                winner_d = DIR_LEFT;
                lw_d     = sat_inc(lw_q);
              end else begin
                pos_d = pos_q - 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
    // Out-of-range positions snap back to the centre.
    if (pos_d > POS_MAX) begin
      pos_d = POS_CTR;
    end
  end

  always_comb begin
    clr_d  = (state_d != ST_ARMED);
    go_d   = (state_d == ST_WIN);
    leds_d = '0;
    leds_d[pos_d] = 1'b1;
  end

  assign clr          = clr_q;
  assign leds         = leds_q;
  assign game_over    = go_q;
  assign winner_right = winner_q;
  assign left_wins    = lw_q;
  assign right_wins   = rw_q;

endmodule

// File: tb/tb_tow_round_ctrl.sv
// Bench for tow_round_ctrl: directed scenarios plus random play, compared
// every cycle against a behavioural model of the game rules.
module tb_tow_round_ctrl;

  localparam int N     = 7;
  localparam int HOLD  = 4;
  localparam int WW    = 2;
  localparam int CTR   = (N - 1) / 2;
  localparam int TMAX  = (1 << WW) - 1;

  localparam int P_REST    = 0;
  localparam int P_READY   = 1;
  localparam int P_PENDING = 2;
  localparam int P_OVER    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic push = 1'b0, tie = 1'b0, right = 1'b0, new_game = 1'b0;
  logic clr, game_over, winner_right;
  logic [N-1:0] leds;
  logic [WW-1:0] left_wins, right_wins;

  int total_cnt = 0;
  int pass_cnt  = 0;

  int m_pos, m_quiet, m_phase, m_lw, m_rw;
  bit m_win_r, m_tie, m_right;

  tow_round_ctrl #(
    .NUM_LEDS(N),
    .HOLD_CYCLES(HOLD),
    .WIN_W(WW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .tie         (tie),
    .right       (right),
    .new_game    (new_game),
    .clr         (clr),
    .leds        (leds),
    .game_over   (game_over),
    .winner_right(winner_right),
    .left_wins   (left_wins),
    .right_wins  (right_wins)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_pos = CTR; m_quiet = 0; m_phase = P_REST;
    m_lw = 0; m_rw = 0; m_win_r = 1'b0; m_tie = 1'b0; m_right = 1'b0;
  endfunction

  // Behavioural model of the rules: a round waits for HOLD quiet cycles,
  // takes one push, then moves the rope one step or declares a winner.
  always @(posedge clk or negedge rst) begin
    int target;
    if (!rst) begin
      model_reset();
    end else if (new_game) begin
      m_pos = CTR; m_quiet = 0; m_phase = P_REST;
    end else begin
      case (m_phase)
        P_REST: begin
          m_quiet = push ? 0 : m_quiet + 1;
          if (m_quiet == HOLD) begin m_phase = P_READY; m_quiet = 0; end
        end
        P_READY: if (push) begin m_tie = tie; m_right = right; m_phase = P_PENDING; end
        P_PENDING: begin
          target = m_tie ? m_pos : (m_right ? m_pos + 1 : m_pos - 1);
          if (target < 0 || target >= N) begin
            m_win_r = m_right;
            if (m_right) m_rw = (m_rw + 1 > TMAX) ? TMAX : m_rw + 1;
            else         m_lw = (m_lw + 1 > TMAX) ? TMAX : m_lw + 1;
            m_phase = P_OVER;
          end else begin
            m_pos = target;
            m_phase = P_REST;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    check("clr", 32'(clr), 32'(m_phase != P_READY));
    check("leds", 32'(leds), 32'(1) << m_pos);
    check("game_over", 32'(game_over), 32'(m_phase == P_OVER));
    check("winner_right", 32'(winner_right), 32'(m_win_r));
    check("left_wins", 32'(left_wins), 32'(m_lw));
    check("right_wins", 32'(right_wins), 32'(m_rw));
  end

  task automatic drive(input bit p, input bit t, input bit r, input bit ng);
    push = p; tie = t; right = r; new_game = ng;
    @(negedge clk);
  endtask

  task automatic score(input bit t, input bit r);
    drive(1'b1, t, r, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rearm();
    int n = 0;
    while (clr !== 1'b0 && n < 16) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("rearm", 32'(clr), 32'd0);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_clr", 32'(clr), 32'd1);
    check("rst_leds", 32'(leds), 32'b0001000);
    check("rst_go", 32'(game_over), 32'd0);
    check("rst_tally", 32'({left_wins, right_wins}), 32'd0);
    #2 rst = 1'b1;
    @(negedge clk);

    // Arming: exactly HOLD quiet edges after reset release.
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("arm_early", 32'(clr), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("arm_edge4", 32'(clr), 32'd0);
    check("arm_leds", 32'(leds), 32'b0001000);

    score(1'b1, 1'b1);
    check("tie_leds", 32'(leds), 32'b0001000);
    check("tie_clr", 32'(clr), 32'd1);
    rearm();

    score(1'b0, 1'b1);
    check("right_leds", 32'(leds), 32'b0010000);
    check("right_clr", 32'(clr), 32'd1);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("rearm_3", 32'(clr), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("rearm_4", 32'(clr), 32'd0);

    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("ng_leds", 32'(leds), 32'b0001000);
    rearm();
    score(1'b0, 1'b0);
    check("left1", 32'(leds), 32'b0000100);
    rearm();
    score(1'b0, 1'b0);
    check("left2", 32'(leds), 32'b0000010);
    rearm();
    score(1'b0, 1'b0);
    check("left3", 32'(leds), 32'b0000001);
    rearm();
    score(1'b0, 1'b0);
    check("lwin_go", 32'(game_over), 32'd1);
    check("lwin_who", 32'(winner_right), 32'd0);
    check("lwin_tally", 32'(left_wins), 32'd1);
    check("lwin_leds", 32'(leds), 32'b0000001);
    check("lwin_clr", 32'(clr), 32'd1);
    repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("win_hold", 32'(leds), 32'b0000001);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("ng2_leds", 32'(leds), 32'b0001000);
    check("ng2_go", 32'(game_over), 32'd0);
    check("ng2_tally", 32'(left_wins), 32'd1);

    // Held button scores once only.
    rearm();
    repeat (20) drive(1'b1, 1'b0, 1'b1, 1'b0);
    check("held_leds", 32'(leds), 32'b0010000);
    check("held_clr", 32'(clr), 32'd1);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("held_rel3", 32'(clr), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("held_rel4", 32'(clr), 32'd0);

    // new_game during the winning SCORE cycle cancels the win.
    score(1'b0, 1'b1);
    rearm();
    score(1'b0, 1'b1);
    check("edge_leds", 32'(leds), 32'b1000000);
    rearm();
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("ngscore_rw", 32'(right_wins), 32'd0);
    check("ngscore_go", 32'(game_over), 32'd0);
    check("ngscore_leds", 32'(leds), 32'b0001000);

    // Asynchronous reset while in SCORE.
    rearm();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    push = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("amid_clr", 32'(clr), 32'd1);
    check("amid_leds", 32'(leds), 32'b0001000);
    check("amid_go", 32'(game_over), 32'd0);
    check("amid_tally", 32'({left_wins, right_wins}), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // Tally saturation with a 2-bit counter.
    for (int w = 0; w < 5; w++) begin
      for (int s = 0; s < 4; s++) begin
        rearm();
        score(1'b0, 1'b1);
      end
      check("sat_go", 32'(game_over), 32'd1);
      check("sat_who", 32'(winner_right), 32'd1);
      check("sat_rw", 32'(right_wins), (w + 1 > 3) ? 32'd3 : 32'(w + 1));
      drive(1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Random play against the model.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 3) == 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 79) == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
